// File: rtl/regfile_bypass_sb_if.sv
// rtl/regfile_bypass_sb_if.sv - operand read, write-back and scoreboard port bundle
interface regfile_bypass_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic              busy1;
  logic              busy2;
  logic              we0;
  logic [ADDR_W-1:0] dest0;
  logic [DATA_W-1:0] wdata0;
  logic              we1;
  logic [ADDR_W-1:0] dest1;
  logic [DATA_W-1:0] wdata1;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_dest;
  logic              flush;

  // Decode/writeback side: drives indices, writes and scoreboard events.
  modport master (
    output src1, src2, we0, dest0, wdata0, we1, dest1, wdata1,
    output issue_en, issue_dest, flush,
    input  reg1, reg2, busy1, busy2
  );

  // Register file side.
  modport slave (
    input  src1, src2, we0, dest0, wdata0, we1, dest1, wdata1,
    input  issue_en, issue_dest, flush,
    output reg1, reg2, busy1, busy2
  );
endinterface

// File: rtl/regfile_bypass_sb.sv
// rtl/regfile_bypass_sb.sv - 2R/2W register file with bypass and pending-write scoreboard
module regfile_bypass_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  regfile_bypass_sb_if.slave  rf
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [NREGS-1:0]  pend_q;
  logic [NREGS-1:0]  pend_d;

  // Writes aimed at register 0 are discarded when it is hardwired to zero.
  logic wr0_ok;
  logic wr1_ok;
  assign wr0_ok = rf.we0 && !((ZERO_REG != 0) && (rf.dest0 == '0));
  assign wr1_ok = rf.we1 && !((ZERO_REG != 0) && (rf.dest1 == '0));

  // Bypass and busy masking are suppressed during reset.
  logic byp_en;
  assign byp_en = (BYPASS != 0) && !rst;

  function automatic logic [DATA_W-1:0] read_data(
    input logic [ADDR_W-1:0] src,
    input logic              byp,
    input logic              we0, we1,
    input logic [ADDR_W-1:0] dest0, dest1,
    input logic [DATA_W-1:0] wdata0, wdata1,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] d;
    if (byp && we1 && (dest1 == src))      d = wdata1;
    else if (byp && we0 && (dest0 == src)) d = wdata0;
    else                                   d = stored;
    if ((ZERO_REG != 0) && (src == '0))    d = '0;
    return d;
  endfunction

  // Combinational operand read with optional same-cycle forwarding.
  always_comb begin
    rf.reg1 = read_data(rf.src1, byp_en, rf.we0, rf.we1, rf.dest0, rf.dest1,
                        rf.wdata0, rf.wdata1, mem_q[rf.src1]);
    rf.reg2 = read_data(rf.src2, byp_en, rf.we0, rf.we1, rf.dest0, rf.dest1,
                        rf.wdata0, rf.wdata1, mem_q[rf.src2]);
  end

  // Busy hides a pending bit only when the producer's value is forwarded this cycle.
  always_comb begin
    logic hit1;
    logic hit2;
    hit1 = (rf.we1 && (rf.dest1 == rf.src1)) || (rf.we0 && (rf.dest0 == rf.src1));
    hit2 = (rf.we1 && (rf.dest1 == rf.src2)) || (rf.we0 && (rf.dest0 == rf.src2));
    rf.busy1 = pend_q[rf.src1] && !(byp_en && hit1) && !rst;
    rf.busy2 = pend_q[rf.src2] && !(byp_en && hit2) && !rst;
  end

  // Scoreboard next state: a new issue beats flush, flush beats write completion.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NREGS; i++) begin
      if (rf.issue_en && (rf.issue_dest == ADDR_W'(i))) begin
        pend_d[i] = 1'b1;
      end else if (rf.flush) begin
        pend_d[i] = 1'b0;
      end else if ((rf.we0 && (rf.dest0 == ADDR_W'(i))) ||
                   (rf.we1 && (rf.dest1 == ADDR_W'(i)))) begin
        pend_d[i] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      pend_d[0] = 1'b0;
    end
  end

  // Register array update; port 1 is written last so it wins a same-index collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr0_ok) begin
        mem_q[rf.dest0] <= rf.wdata0;
      end
      if (wr1_ok) begin
        mem_q[rf.dest1] <= rf.wdata1;
      end
    end
  end

  // Pending-bit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end
endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
Parametrised successor to the pipeline's register file: two read ports, two write ports, optional same-cycle write-to-read bypass and a per-register pending-write scoreboard. The decode stage uses it to fetch operands and detect RAW hazards. Writeback (WB) drives write port 1, and a late/secondary producer drives write port 0. All state updates happen on the rising clock edge; reads are combinational.

Parameters:
DATA_W, 32, register data width in bits.
ADDR_W, 5, register index width; the file holds 2**ADDR_W registers.
ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never pending.
BYPASS, 1, when 1, read ports forward same-cycle write data.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
src1  in  ADDR_W  read port 1 index.
src2  in  ADDR_W  read port 2 index.
reg1  out  DATA_W  read port 1 data.
reg2  out  DATA_W  read port 2 data.
busy1  out  1  register src1 has an outstanding producer.
busy2  out  1  register src2 has an outstanding producer.
we0  in  1  write enable, port 0.
dest0  in  ADDR_W  write index, port 0.
wdata0  in  DATA_W  write data, port 0.
we1  in  1  write enable, port 1 (WB; higher priority).
dest1  in  ADDR_W  write index, port 1.
wdata1  in  DATA_W  write data, port 1.
issue_en  in  1  an instruction writing issue_dest is issued this cycle.
issue_dest  in  ADDR_W  destination of the issued instruction.
flush  in  1  clear all pending bits (pipeline squash).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at posedge): all registers <= 0 and all pending bits <= 0. Writes, issue and flush are ignored in that cycle. While rst=1, bypass and busy are forced inactive; reads return stored contents.
- After reset: reg1=reg2=0 and busy1=busy2=0 for any src.
- Write: at posedge, if weN and not rst, mem[destN] <= wdataN.
- Dual write to the same index in one cycle: port 1 wins and the port 0 write is discarded.
- ZERO_REG=1: writes to index 0 are dropped and mem[0] always reads as 0, including through the bypass.
- Read, BYPASS=0: regN = mem[srcN], so written data is visible the cycle after the write edge.
- Read, BYPASS=1: priority is (we1 & dest1==src) -> wdata1, else (we0 & dest0==src) -> wdata0, else mem[src]. A zero-register hit with ZERO_REG=1 returns 0.
- Read latency: combinational, 0 cycles.
- Scoreboard: one pending bit per register.
- Next-state priority per index i, highest first:
  1. rst -> 0.
  2. issue_en & issue_dest==i -> 1.
  3. flush -> 0.
  4. write to i on either port -> 0.
  5. Otherwise hold.
- Issue to an already-pending register keeps it pending (single outstanding producer tracked). Issue and a write to the same index in the same cycle leave it pending, because the new producer wins.
- Index 0 with ZERO_REG=1 never goes pending.
- busyN = pending[srcN] & ~(BYPASS & a same-cycle write hit on srcN) & ~rst.
  - With BYPASS=0, busy stays asserted during the write cycle and drops the cycle after.
  - Same-cycle issue_en does not affect busy until the next cycle.
- Reset mid-operation: any pending writes or issues in the reset cycle are lost. The file is all-zero and non-pending on the next cycle.

Test Plan:
- Reset: preload r5=0xDEADBEEF, assert rst for 1 cycle with we1=1 dest1=6 -> next cycle reg1(src=5)=0, reg2(src=6)=0, busy1=busy2=0.
- Bypass and priority: BYPASS=1, we0=1 dest0=7 wdata0=0x11, we1=1 dest1=7 wdata1=0x22, src1=7 -> reg1=0x22 in the same cycle; next cycle mem[7]=0x22. With BYPASS=0 -> reg1 shows the old value, then 0x22 the next cycle.
- Zero register: we1=1 dest1=0 wdata1=0xFFFF, issue_en dest 0 -> reg1(src=0)=0 and busy1=0, both same cycle and next.
- Scoreboard lifecycle: issue r3; next cycle busy1(src=3)=1. Two cycles later we1 dest1=3 -> busy1=0 in that cycle (BYPASS=1), and 1 in that cycle then 0 after (BYPASS=0).
- Simultaneous issue and write: r4 pending; issue_en r4 and we1 dest1=4 in the same cycle -> next cycle busy(src=4)=1, mem[4]=wdata1.
- Flush: r2, r9 pending; flush=1 together with issue_en r9 -> next cycle busy(r2)=0, busy(r9)=1. Register data is unchanged.
